sysid_checker: RTL

- Avalon-MM read master that sequences a boot-time identity check of the system-ID slave in the Ethernet subsystem.
- Reads word 0 (system ID) and word 1 (timestamp), compares both against build-time expected values, and reports sticky pass/fail to the control/status logic.
- Handles waitrequest, variable read latency via readdatavalid, per-transaction timeout and bounded retries; re-runs on request.

---
 rtl/sysid_checker.sv | 198 +++++++++++++++++++
 1 files changed

// File: rtl/sysid_checker.sv
// Boot-time identity check of the system-ID slave: reads ID and timestamp words over Avalon-MM,
// compares them against build-time values and reports sticky pass/fail with timeout retries.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID = 32'h0000_0000,
    parameter logic [31:0] EXPECTED_TS = 32'h0000_0000,
    parameter bit          CHECK_TS    = 1'b1,
    parameter int unsigned TIMEOUT     = 255,
    parameter int unsigned MAX_RETRIES = 3,
    parameter bit          AUTO_START  = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic [3:0]  retry_count
);

    typedef enum logic [2:0] {
        StIdle,
        StIdReq,
        StIdWait,
        StTsReq,
        StTsWait,
        StCompare,
        StFinish
    } state_e;

    localparam logic [15:0] TimerInit  = 16'(TIMEOUT);
    localparam logic [3:0]  RetryLimit = 4'(MAX_RETRIES);

    state_e      state_q, state_d;
    logic [15:0] timer_q, timer_d;
    logic [3:0]  retry_q, retry_d;
    logic [31:0] id_q, id_d;
    logic [31:0] ts_q, ts_d;
    logic        read_q, read_d;
    logic        addr_q, addr_d;
    logic        done_q, done_d;
    logic        pass_q, pass_d;
    logic        fail_q, fail_d;
    logic        tmo_q, tmo_d;
    logic        auto_q, auto_d;
    logic        expire;
    logic        words_match;

    assign words_match = (id_q == EXPECTED_ID) && (!CHECK_TS || (ts_q == EXPECTED_TS));

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        retry_d = retry_q;
        id_d    = id_q;
        ts_d    = ts_q;
        read_d  = read_q;
        addr_d  = addr_q;
        done_d  = done_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        tmo_d   = tmo_q;
        auto_d  = 1'b0;
        expire  = 1'b0;

        // The budget spans both the request and the response wait of one word.
        if ((state_q inside {StIdReq, StIdWait, StTsReq, StTsWait}) && (timer_q != 16'd0)) begin
            timer_d = timer_q - 16'd1;
        end

        unique case (state_q)
            StIdle: begin
                if (start || auto_q) begin
                    state_d = StIdReq;
                    timer_d = TimerInit;
                    retry_d = 4'd0;
                    done_d  = 1'b0;
                    pass_d  = 1'b0;
                    fail_d  = 1'b0;
                    tmo_d   = 1'b0;
                    read_d  = 1'b1;
                    addr_d  = 1'b0;
                end
            end
            StIdReq: begin
                if (!avm_waitrequest) begin
                    state_d = StIdWait;
                    read_d  = 1'b0;
                end else begin
                    expire = (timer_q == 16'd0);
                end
            end
            StIdWait: begin
                if (avm_readdatavalid) begin
                    id_d    = avm_readdata;
                    state_d = StTsReq;
                    timer_d = TimerInit;
                    read_d  = 1'b1;
                    addr_d  = 1'b1;
                end else begin
                    expire = (timer_q == 16'd0);
                end
            end
            StTsReq: begin
                if (!avm_waitrequest) begin
                    state_d = StTsWait;
                    read_d  = 1'b0;
                end else begin
                    expire = (timer_q == 16'd0);
                end
            end
            StTsWait: begin
                if (avm_readdatavalid) begin
                    ts_d    = avm_readdata;
                    state_d = StCompare;
                end else begin
                    expire = (timer_q == 16'd0);
                end
            end
            StCompare: begin
                pass_d  = words_match;
                fail_d  = !words_match;
                state_d = StFinish;
            end
            StFinish: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // A timeout anywhere restarts from word 0 so both words come from the same attempt.
        if (expire) begin
            if (retry_q < RetryLimit) begin
                retry_d = retry_q + 4'd1;
                state_d = StIdReq;
                timer_d = TimerInit;
                read_d  = 1'b1;
                addr_d  = 1'b0;
            end else begin
                fail_d  = 1'b1;
                tmo_d   = 1'b1;
                state_d = StFinish;
                read_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= StIdle;
            timer_q <= 16'd0;
            retry_q <= 4'd0;
            id_q    <= 32'd0;
            ts_q    <= 32'd0;
            read_q  <= 1'b0;
            addr_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 1'b0;
            tmo_q   <= 1'b0;
            auto_q  <= AUTO_START;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            retry_q <= retry_d;
            id_q    <= id_d;
            ts_q    <= ts_d;
            read_q  <= read_d;
            addr_q  <= addr_d;
            done_q  <= done_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
            tmo_q   <= tmo_d;
            auto_q  <= auto_d;
        end
    end

    assign avm_read    = read_q;
    assign avm_address = addr_q;
    assign busy        = (state_q != StIdle);
    assign done        = done_q;
    assign pass        = pass_q;
    assign fail        = fail_q;
    assign timeout_err = tmo_q;
    assign id_value    = id_q;
    assign ts_value    = ts_q;
    assign retry_count = retry_q;

endmodule
